// File: rtl/prog_loader_pkg.sv
// Shared types and default sizes for the program loader.
// The echo option is enabled by defining PROG_LOADER_ECHO_EN in the top (prog_loader).
package prog_loader_pkg;

  localparam int IW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_receiving(loader_state_t s);
    return (s == LEN) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Modular byte sum over the image payload, with equality compare against a
// received checksum byte.
module loader_checksum
  import prog_loader_pkg::*;
#(
  parameter int W = IW_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] byte_i,
  input  logic [W-1:0] cmp_i,
  output logic         match_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/prog_loader.sv
// Writes a length-prefixed, checksummed byte image into instruction memory
// while holding the CPU. Optional byte echo: define PROG_LOADER_ECHO_EN.
//
// state | meaning
// IDLE  | waiting for load_req, CPU running
// LEN   | expecting the length byte
// DATA  | expecting payload bytes, one imem write each
// CHECK | expecting the checksum byte
// DONE  | last load succeeded, CPU released
// ERROR | last load failed, CPU still held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          sysclk,
  input  logic          sysrst_n,
  input  logic          load_req,
  input  logic          rx_valid,
  input  logic [IW-1:0] rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
`ifdef PROG_LOADER_ECHO_EN
  output logic          tx_valid,
  output logic [IW-1:0] tx_data,
  input  logic          tx_ready,
`endif
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam int LW = $clog2(DEPTH + 1);

  loader_state_t state_q, state_d;
  logic [AW-1:0] counter_q, counter_d;
  logic [LW-1:0] len_q, len_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] wdata_q, wdata_d;

  logic accept;
  logic last_byte;
  logic sum_clr;
  logic sum_en;
  logic sum_match;

  // Echo back-pressure: a stalled echo register blocks the receive side.
`ifdef PROG_LOADER_ECHO_EN
  logic          tx_valid_q;
  logic [IW-1:0] tx_data_q;

  assign rx_ready = is_receiving(state_q) && !(tx_valid_q && !tx_ready);
`else
  assign rx_ready = is_receiving(state_q);
`endif

  assign accept    = rx_valid && rx_ready;
  assign last_byte = ((LW'(counter_q) + LW'(1)) == len_q);

  loader_checksum #(
    .W(IW)
  ) u_checksum (
    .clk_i  (sysclk),
    .rst_n_i(sysrst_n),
    .clr_i  (sum_clr),
    .en_i   (sum_en),
    .byte_i (rx_data),
    .cmp_i  (rx_data),
    .match_o(sum_match)
  );

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    len_d      = len_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sum_clr    = 1'b0;
    sum_en     = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_req) begin
          state_d    = LEN;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          counter_d  = '0;
          sum_clr    = 1'b1;
        end
      end
      LEN: begin
        if (accept) begin
          if ((rx_data == '0) || (int'(rx_data) > DEPTH)) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            len_d   = LW'(rx_data);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = counter_q;
          wdata_d = rx_data;
          sum_en  = 1'b1;
          // Hold the counter on the final byte so a full-depth image never wraps it.
          if (last_byte) begin
            state_d = CHECK;
          end else begin
            counter_d = counter_q + AW'(1);
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (sum_match) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      len_q      <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      len_q      <= len_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef PROG_LOADER_ECHO_EN
  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (accept) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= rx_data;
    end else if (tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`endif

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface that the CPU datapath reads through its PC.
- Accepts a byte stream from the serial receive front-end and writes a length-prefixed, checksummed program image into instruction memory.
- Holds the CPU in hold while loading, then releases it.
- Sits between the UART RX byte stream and the write port of instructMem.

Parameters:
- IW, 8, instruction/byte width in bits.
- AW, 4, instruction memory address width.
- DEPTH, 16, maximum program length in instructions; must be ≤ 2**AW.

Ports:
- sysclk  input  1  system clock; all logic on rising edge.
- sysrst_n  input  1  synchronous, active-low reset.
- load_req  input  1  single-cycle request to start a load.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  IW  received byte.
- rx_ready  output  1  loader accepts the byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  AW  write address.
- imem_wdata  output  IW  write data.
- cpu_hold  output  1  holds the CPU (PC frozen, no register writes).
- done  output  1  last load succeeded.
- error  output  1  last load failed.

Behaviour:
- Reset (sysrst_n=0 at an edge):
  - state=IDLE, counter=0, sum=0, len=0.
  - Outputs: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, error=0.
- Byte acceptance: a byte is accepted only on a cycle where rx_valid && rx_ready.
- States: IDLE, LEN, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR on load_req=1:
  - Next state LEN; cpu_hold=1 next cycle.
  - done=0, error=0, sum=0, counter=0.
  - load_req is ignored in LEN/DATA/CHECK.
- LEN: accepted byte L.
  - L==0 or L>DEPTH → ERROR.
  - Otherwise len=L, next state DATA.
- DATA: each accepted byte B:
  - One cycle later: imem_we=1, imem_addr=counter, imem_wdata=B; registered, 1-cycle latency.
  - sum=sum+B mod 2**IW; counter increments.
  - When the accepted byte is number len (counter==len-1), next state CHECK.
  - Back-to-back bytes are accepted one per cycle.
- CHECK: accepted byte C.
  - C==sum → DONE, done=1, cpu_hold=0.
  - Otherwise → ERROR, error=1, cpu_hold stays 1.
- rx_ready:
  - 1 in LEN, DATA and CHECK, except while blocked by the optional echo.
  - 0 in IDLE, DONE and ERROR.
- imem_we is never high outside the cycle following a DATA accept.
- Address range: a loaded image occupies addresses 0..len-1 only; the counter never wraps because len ≤ DEPTH.
- done and error are mutually exclusive. Both are sticky until the next load_req or reset.
- Reset mid-load: everything returns to reset values.
  - cpu_hold drops to 0.
  - Any pending imem write is dropped.
  - Words already written stay in memory.

Optional Feature:
- Macro: PROG_LOADER_ECHO_EN.
- With it defined:
  - Added ports: tx_valid (output, 1), tx_data (output, IW), tx_ready (input, 1).
  - Every accepted byte is presented on tx_data with tx_valid=1 starting the next cycle, held until tx_ready=1.
  - rx_ready=0 while tx_valid && !tx_ready. A byte accepted on the same cycle as a tx handshake replaces the echo register.
  - Reset values: tx_valid=0, tx_data=0.
- Without it: no tx ports; rx_ready depends only on state.

Decomposition:
- Shared package prog_loader_pkg:
  - State enum loader_state_t (IDLE, LEN, DATA, CHECK, DONE, ERROR).
  - Default widths IW_DEF=8, AW_DEF=4, DEPTH_DEF=16.
- One sub-module, loader_checksum:
  - Clear, accumulate-on-enable 8-bit modular sum; compare output against an input byte.
- FSM, counter and imem write register stay in prog_loader.

Test Plan:
- Good load: load_req, then bytes 0x03, 0x12, 0x34, 0x56, 0x9C on consecutive cycles.
  - Writes (0,0x12), (1,0x34), (2,0x56), each one cycle after its accept.
  - Then done=1, cpu_hold=0, error=0.
- Bad checksum: same image with checksum byte 0x00.
  - Three writes occur, then error=1, cpu_hold=1, done=0.
- Length bounds:
  - Length byte 0x00 → ERROR with no writes.
  - Length 0x11 (17 > DEPTH) → ERROR with no writes.
  - Length 0x10 with 16 data bytes plus correct checksum → writes 0..15, then done=1.
- Gaps: rx_valid toggled 1-0-1 across the good-load image → identical writes and done=1.
  - load_req pulsed during DATA is ignored.
- Reset mid-load: sysrst_n=0 after the 2nd data byte.
  - Next cycle all outputs are at reset values; no further imem_we.
  - A following good load succeeds.
- Echo (PROG_LOADER_ECHO_EN): tx_ready held 0 for 3 cycles after the first accept.
  - rx_ready=0 during those cycles; tx_data=0x03 stable.
  - On release, the stream continues and the echoed sequence equals the input.
